crc_tx_sequencer: RTL and testbench
===================================

CRC_TX_SEQUENCER -- requirements
Module: crc_tx_sequencer

Interface
REQ-001 SHALL have port Clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port TxStart  in  1  frame request, sampled in IDLE only.
REQ-004 SHALL have port TxData  in  4  payload nibble, LSB-first order.
REQ-005 SHALL have port TxValid  in  1  TxData valid.
REQ-006 SHALL have port TxLast  in  1  marks final payload nibble.
REQ-007 SHALL have port TxReady  out  1  nibble accepted when TxValid&TxReady.
REQ-008 SHALL have port CrcInit  out  1  drives the CRC engine Initialize input.
REQ-009 SHALL have port CrcEnable  out  1  drives the CRC engine Enable input.
REQ-010 SHALL have port CrcData  out  4  drives the CRC engine Data input.
REQ-011 SHALL have port Crc  in  32  CRC engine register value.
REQ-012 SHALL have port MiiTxd  out  4  registered MII transmit nibble.
REQ-013 SHALL have port MiiTxEn  out  1  registered MII transmit enable.
REQ-014 SHALL have port TxDone  out  1  one-cycle pulse on good frame end.
REQ-015 SHALL have port TxUnderrun  out  1  one-cycle pulse on aborted frame.

Function
REQ-016 SHALL implement states IDLE, PREAMBLE, DATA, PAD, CRC, IFG; PAD exists only with CRC_TX_PAD_EN.
REQ-017 SHALL, on TxStart=1 in IDLE at cycle t, drive MiiTxEn=1 from t+1, MiiTxd=0x5 for t+1..t+15, MiiTxd=0xD at t+16.
REQ-018 SHALL hold CrcInit=1 in IDLE, PREAMBLE, IFG; CrcInit=0 in DATA, PAD, CRC.
REQ-019 SHALL drive TxReady=1 only in DATA, first at cycle t+16.
REQ-020 SHALL, in DATA, drive CrcData=TxData and CrcEnable=TxValid&TxReady combinationally; each accepted nibble appears on MiiTxd one cycle later.
REQ-021 SHALL keep a 12-bit payload nibble counter, cleared in IDLE, incremented per accepted/padded nibble.
REQ-022 SHALL, on an accepted nibble with TxLast=1, go to CRC (or PAD, per REQ-031) next cycle.
REQ-023 SHALL, in CRC, hold CrcEnable=0 for exactly 8 cycles; each cycle register MiiTxd = {~Crc[28],~Crc[29],~Crc[30],~Crc[31]}.
REQ-024 SHALL assert TxDone in the cycle the eighth CRC nibble is on MiiTxd; MiiTxEn drops the following cycle.
REQ-025 SHALL, in IFG, hold MiiTxEn=0 for 24 cycles, then return to IDLE; TxStart ignored outside IDLE.
REQ-026 SHALL, on TxValid=0 in DATA (underrun), drop MiiTxEn next cycle, pulse TxUnderrun that cycle, skip CRC, enter IFG.
REQ-027 SHALL ignore TxLast without TxValid, and TxData when not accepted.

Reset
REQ-028 SHALL, on Reset=1, asynchronously enter IDLE: MiiTxEn=0, MiiTxd=0x0, TxReady=0, TxDone=0, TxUnderrun=0, counter=0, CrcInit=1.
REQ-029 SHALL abandon any frame in progress on Reset without emitting CRC nibbles.
REQ-030 SHALL resume normal operation at the first clock edge after Reset deasserts.

Configuration
REQ-031 SHALL, with CRC_TX_PAD_EN defined, when TxLast is accepted with counter<120 (including that nibble), enter PAD: TxReady=0, CrcEnable=1, CrcData=0x0, MiiTxd=0x0 until counter=120, then CRC.
REQ-032 SHALL, without CRC_TX_PAD_EN, omit PAD state and send short frames unpadded straight into CRC.

Verification
REQ-033 SHALL verify: TxStart at t -> 15x 0x5 then 0xD on MiiTxd at t+1..t+16, TxReady first at t+16.
REQ-034 SHALL verify: 128-nibble payload with TxLast on 128th -> MiiTxd post-SFD stream run through a model CRC engine leaves residue 32'hc704dd7b; TxDone once; 24 idle cycles before TxReady returns.
REQ-035 SHALL verify: TxValid dropped after 40 nibbles -> TxUnderrun pulse, MiiTxEn low next cycle, no TxDone, no CRC nibbles.
REQ-036 SHALL verify (CRC_TX_PAD_EN): 20-nibble payload -> 100 zero nibbles then 8 CRC nibbles, residue 32'hc704dd7b; without macro, CRC immediately after nibble 20.
REQ-037 SHALL verify: Reset pulsed mid-CRC phase -> MiiTxEn=0 immediately, IDLE, next TxStart produces a correct frame.
REQ-038 SHALL verify: TxStart held high during DATA and IFG -> no effect; new frame only after IDLE reached.

Source files
------------

// File: rtl/crc_tx_sequencer.sv
// ============================================================================
// crc_tx_sequencer : MII nibble transmit framer (preamble/SFD, payload, CRC,
// inter-frame gap) steering an external CRC-32 engine. Optional CRC_TX_PAD_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module crc_tx_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        TxStart,
    input  logic [3:0]  TxData,
    input  logic        TxValid,
    input  logic        TxLast,
    output logic        TxReady,
    output logic        CrcInit,
    output logic        CrcEnable,
    output logic [3:0]  CrcData,
    input  logic [31:0] Crc,
    output logic [3:0]  MiiTxd,
    output logic        MiiTxEn,
    output logic        TxDone,
    output logic        TxUnderrun
);

`ifdef CRC_TX_PAD_EN
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DATA, S_CRC, S_IFG, S_PAD
    } state_t;
    localparam logic [11:0] c_MIN_NIBBLES = 12'd120;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DATA, S_CRC, S_IFG
    } state_t;
`endif

    localparam logic [4:0] c_PRE_LAST = 5'd14;
    localparam logic [4:0] c_CRC_LAST = 5'd7;
    localparam logic [4:0] c_IFG_LAST = 5'd23;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [11:0] nib_q;
    logic [11:0] nib_d;
    logic [3:0]  txd_q;
    logic        txen_q;
    logic        ready_q;
    logic        init_q;
    logic        done_q;
    logic        urun_q;
    logic        w_crc_unused;

    // Only the top nibble of the engine register is serialised each cycle.
    assign w_crc_unused = ^Crc[27:0];
    assign nib_d        = nib_q + 12'd1;

    assign TxReady    = ready_q;
    assign CrcInit    = init_q;
    assign MiiTxd     = txd_q;
    assign MiiTxEn    = txen_q;
    assign TxDone     = done_q;
    assign TxUnderrun = urun_q;

    always_comb begin
        CrcEnable = 1'b0;
        CrcData   = 4'h0;
        if (state_q == S_DATA) begin
            CrcEnable = TxValid & ready_q;
            CrcData   = TxData;
        end
`ifdef CRC_TX_PAD_EN
        if (state_q == S_PAD) begin
            CrcEnable = 1'b1;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nib_q   <= '0;
            txd_q   <= 4'h0;
            txen_q  <= 1'b0;
            ready_q <= 1'b0;
            init_q  <= 1'b1;
            done_q  <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            urun_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    nib_q <= '0;
                    cnt_q <= '0;
                    if (TxStart) begin
                        state_q <= S_PREAMBLE;
                        txen_q  <= 1'b1;
                        txd_q   <= 4'h5;
                    end
                end
                S_PREAMBLE: begin
                    if (cnt_q == c_PRE_LAST) begin
                        state_q <= S_DATA;
                        txd_q   <= 4'hD;
                        ready_q <= 1'b1;
                        init_q  <= 1'b0;
                    end else begin
                        txd_q <= 4'h5;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                S_DATA: begin
                    if (TxValid) begin
                        txd_q <= TxData;
                        nib_q <= nib_d;
                        if (TxLast) begin
                            ready_q <= 1'b0;
                            cnt_q   <= '0;
`ifdef CRC_TX_PAD_EN
                            state_q <= (nib_d < c_MIN_NIBBLES) ? S_PAD : S_CRC;
`else
                            state_q <= S_CRC;
`endif
                        end
                    end else begin
                        // Underrun: abandon the frame without a CRC.
                        state_q <= S_IFG;
                        txen_q  <= 1'b0;
                        txd_q   <= 4'h0;
                        ready_q <= 1'b0;
                        init_q  <= 1'b1;
                        urun_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
`ifdef CRC_TX_PAD_EN
                S_PAD: begin
                    txd_q <= 4'h0;
                    nib_q <= nib_d;
                    if (nib_d == c_MIN_NIBBLES) begin
                        state_q <= S_CRC;
                    end
                end
`endif
                S_CRC: begin
                    txd_q <= {~Crc[28], ~Crc[29], ~Crc[30], ~Crc[31]};
                    if (cnt_q == c_CRC_LAST) begin
                        state_q <= S_IFG;
                        done_q  <= 1'b1;
                        init_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                S_IFG: begin
                    txen_q <= 1'b0;
                    txd_q  <= 4'h0;
                    // The gap is timed from the first cycle with the enable low.
                    if (!txen_q) begin
                        if (cnt_q == c_IFG_LAST) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_crc_tx_sequencer.sv
// ============================================================================
// tb_crc_tx_sequencer : directed self-checking bench for crc_tx_sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_crc_tx_sequencer;

    logic        Clk;
    logic        Reset;
    logic        TxStart;
    logic [3:0]  TxData;
    logic        TxValid;
    logic        TxLast;
    logic        TxReady;
    logic        CrcInit;
    logic        CrcEnable;
    logic [3:0]  CrcData;
    logic [31:0] Crc;
    logic [3:0]  MiiTxd;
    logic        MiiTxEn;
    logic        TxDone;
    logic        TxUnderrun;

    crc_tx_sequencer u_dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .TxStart    (TxStart),
        .TxData     (TxData),
        .TxValid    (TxValid),
        .TxLast     (TxLast),
        .TxReady    (TxReady),
        .CrcInit    (CrcInit),
        .CrcEnable  (CrcEnable),
        .CrcData    (CrcData),
        .Crc        (Crc),
        .MiiTxd     (MiiTxd),
        .MiiTxEn    (MiiTxEn),
        .TxDone     (TxDone),
        .TxUnderrun (TxUnderrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Serial CRC-32 (poly 04C11DB7), nibble bit 0 first, as on the wire.
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 4; i++) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return r;
    endfunction

    // External CRC engine: initialise, accumulate, or shift the result out.
    always @(posedge Clk) begin
        if (CrcInit)        Crc <= 32'hFFFFFFFF;
        else if (CrcEnable) Crc <= crc_nib(Crc, CrcData);
        else                Crc <= {Crc[27:0], 4'h0};
    end

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          t0       = 0;
    int          idx      = 0;
    int          limit    = 0;
    int          pay_n    = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          urun_cnt = 0;
    int          urun_cyc = -1;
    int          rise_cnt = 0;
    int          rise_cyc = -1;
    int          fall_cyc = -1;
    int          first_rdy = -1;
    logic        en_prev  = 1'b0;
    logic [3:0]  pay [128];
    logic [3:0]  txq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive the next inputs.
    task automatic step();
        @(negedge Clk);
        cyc++;
        if (MiiTxEn) txq.push_back(MiiTxd);
        if (TxDone) begin done_cnt++; done_cyc = cyc; end
        if (TxUnderrun) begin urun_cnt++; urun_cyc = cyc; end
        if (TxReady && first_rdy < 0) first_rdy = cyc;
        if (MiiTxEn && !en_prev) begin rise_cnt++; rise_cyc = cyc; end
        if (!MiiTxEn && en_prev) fall_cyc = cyc;
        en_prev = MiiTxEn;
        if (idx < limit) begin
            TxValid = 1'b1;
            TxData  = pay[idx];
            TxLast  = (idx == pay_n - 1);
            if (TxReady) idx++;
        end else begin
            TxValid = 1'b0;
            TxLast  = 1'b0;
            TxData  = 4'h0;
        end
    endtask

    task automatic start_frame(input int n, input int lim, input bit hold);
        for (int i = 0; i < 128; i++) pay[i] = 4'((i * 7 + n + (i >> 4)) & 15);
        pay_n = n; limit = lim; idx = 0;
        txq.delete();
        done_cnt = 0; urun_cnt = 0; rise_cnt = 0; first_rdy = -1;
        done_cyc = -1; urun_cyc = -1; rise_cyc = -1; fall_cyc = -1;
        TxStart = 1'b1;
        t0 = cyc;
        step();
        if (!hold) TxStart = 1'b0;
    endtask

    task automatic run_to_end(input string tag, input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && urun_cnt == 0 && k < budget) begin
            step();
            k++;
        end
        check({tag, "_end_in_time"}, 32'(k < budget), 32'd1);
        step();
        step();
    endtask

    task automatic check_good_frame(input string tag, input int n);
        int          eff;
        int          bad;
        logic [31:0] r;
        logic        pre_ok;
        eff = n;
`ifdef CRC_TX_PAD_EN
        if (eff < 120) eff = 120;
`endif
        check({tag, "_en_rise"}, rise_cyc, t0 + 1);
        check({tag, "_first_ready"}, first_rdy, t0 + 16);
        check({tag, "_nibbles"}, txq.size(), 16 + eff + 8);
        while (txq.size() < 16 + eff + 8) txq.push_back(4'hx);
        pre_ok = (txq[15] === 4'hD);
        for (int i = 0; i < 15; i++) if (txq[i] !== 4'h5) pre_ok = 1'b0;
        check({tag, "_preamble_sfd"}, 32'(pre_ok), 32'd1);
        bad = 0;
        for (int i = 0; i < n; i++) if (txq[16 + i] !== pay[i]) bad++;
        for (int i = n; i < eff; i++) if (txq[16 + i] !== 4'h0) bad++;
        check({tag, "_payload_bad"}, bad, 0);
        r = 32'hFFFFFFFF;
        for (int i = 16; i < 16 + eff; i++) r = crc_nib(r, txq[i]);
        check({tag, "_crc_first"}, 32'(txq[16 + eff]), 32'({~r[28], ~r[29], ~r[30], ~r[31]}));
        for (int i = 16 + eff; i < 16 + eff + 8; i++) r = crc_nib(r, txq[i]);
        check({tag, "_residue"}, r, 32'hC704DD7B);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_cyc, t0 + 16 + eff + 8);
        check({tag, "_en_fall"}, fall_cyc, t0 + 16 + eff + 9);
        check({tag, "_no_underrun"}, urun_cnt, 0);
    endtask

    initial begin
        Reset   = 1'b1;
        TxStart = 1'b0;
        TxData  = 4'h0;
        TxValid = 1'b0;
        TxLast  = 1'b0;
        step(); step(); step();
        check("rst_txen", 32'(MiiTxEn), 32'd0);
        check("rst_txd", 32'(MiiTxd), 32'd0);
        check("rst_ready", 32'(TxReady), 32'd0);
        check("rst_done", 32'(TxDone), 32'd0);
        check("rst_underrun", 32'(TxUnderrun), 32'd0);
        check("rst_crcinit", 32'(CrcInit), 32'd1);
        check("rst_crcen", 32'(CrcEnable), 32'd0);
        Reset = 1'b0;
        step(); step();

        // Full 128-nibble frame with TxStart held high throughout.
        start_frame(128, 128, 1'b1);
        run_to_end("f128", 400);
        check_good_frame("f128", 128);
        begin
            int k;
            k = 0;
            while (rise_cnt < 2 && k < 100) begin step(); k++; end
        end
        check("held_start_next_rise", rise_cyc, t0 + 178);

        // Asynchronous reset between clock edges during the new preamble.
        Reset = 1'b1;
        #1;
        check("async_rst_txen", 32'(MiiTxEn), 32'd0);
        check("async_rst_crcinit", 32'(CrcInit), 32'd1);
        TxStart = 1'b0;
        limit = 0;
        step(); step();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Underrun after 40 nibbles.
        start_frame(128, 40, 1'b0);
        run_to_end("urun", 400);
        check("urun_pulse_cycle", urun_cyc, t0 + 57);
        check("urun_count", urun_cnt, 1);
        check("urun_en_fall", fall_cyc, t0 + 57);
        check("urun_no_done", done_cnt, 0);
        check("urun_nibbles", txq.size(), 56);
        for (int i = 0; i < 30; i++) step();

        // Short 20-nibble frame (padded when the pad option is built in).
        start_frame(20, 20, 1'b0);
        run_to_end("f20", 400);
        check_good_frame("f20", 20);
        for (int i = 0; i < 30; i++) step();

        // Reset in the middle of the CRC phase, then a clean frame.
        start_frame(128, 128, 1'b0);
        while (cyc < t0 + 148) step();
        check("mid_crc_txen_before", 32'(MiiTxEn), 32'd1);
        limit = 0;
        Reset = 1'b1;
        #1;
        check("mid_crc_rst_txen", 32'(MiiTxEn), 32'd0);
        check("mid_crc_rst_txd", 32'(MiiTxd), 32'd0);
        check("mid_crc_rst_ready", 32'(TxReady), 32'd0);
        rise_cnt = 0;
        step(); step();
        Reset = 1'b0;
        for (int i = 0; i < 30; i++) step();
        check("mid_crc_no_done", done_cnt, 0);
        check("mid_crc_stays_idle", rise_cnt, 0);
        start_frame(32, 32, 1'b0);
        run_to_end("f32", 400);
        check_good_frame("f32", 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
